bc_arb_buffer: RTL and testbench

Parametrised two-source buffer between the controller (`ctrl`) and obstacle-avoidance (`avoid`) paths and the downstream drive command consumer. Each source writes into its own FIFO; a registered output stage arbitrates between them under a selectable policy and presents one word per cycle with a valid/ready handshake. It supersedes the single-FIFO bc buffer in the control datapath and is generalised in data width, depth and arbitration mode.

---
 rtl/bc_pkg.sv | 14 +
 rtl/bc_fifo.sv | 72 +++++++
 rtl/bc_arb_buffer.sv | 145 ++++++++++++++
 tb/tb_bc_arb_buffer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// Shared types and constants for the two-source arbitrated command buffer.
package bc_pkg;

    typedef enum logic {
        BC_SRC_CTRL  = 1'b0,
        BC_SRC_AVOID = 1'b1
    } bc_src_e;

    localparam int BC_MODE_PRIO  = 0;
    localparam int BC_MODE_RR    = 1;
    localparam int BC_DATA_W_DEF = 16;
    localparam int BC_DEPTH_DEF  = 8;

endpackage

// File: rtl/bc_fifo.sv
// Single-source FIFO: power-of-two depth, DEPTH+1-valued occupancy count,
// synchronous flush, push refused when full regardless of same-cycle pop.
module bc_fifo
    import bc_pkg::*;
#(
    parameter  int DATA_W = BC_DATA_W_DEF,
    parameter  int DEPTH  = BC_DEPTH_DEF,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/bc_arb_buffer.sv
// Two-source (ctrl/avoid) FIFO buffer with registered arbitrated output.
// Optional drop counters: define BC_ARB_BUFFER_DROP_CNT_EN.
module bc_arb_buffer
    import bc_pkg::*;
#(
    parameter  int DATA_W = BC_DATA_W_DEF,
    parameter  int DEPTH  = BC_DEPTH_DEF,
    parameter  int MODE   = BC_MODE_PRIO,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ctrl_valid,
    input  logic [DATA_W-1:0] ctrl_data,
    output logic              ctrl_ready,
    input  logic              avoid_valid,
    input  logic [DATA_W-1:0] avoid_data,
    output logic              avoid_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    input  logic              out_ready,
`ifdef BC_ARB_BUFFER_DROP_CNT_EN
    output logic [7:0]        ctrl_drops,
    output logic [7:0]        avoid_drops,
`endif
    output logic [CW-1:0]     ctrl_count,
    output logic [CW-1:0]     avoid_count
);

    logic [DATA_W-1:0] c_data, a_data;
    logic              c_full, c_empty, a_full, a_empty;
    logic              c_pop, a_pop, load, sel_avoid;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    bc_src_e           out_src_q, out_src_d;
    bc_src_e           last_q, last_d;

    bc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ctrl_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (ctrl_valid),
        .push_data (ctrl_data),
        .pop       (c_pop),
        .pop_data  (c_data),
        .count     (ctrl_count),
        .full      (c_full),
        .empty     (c_empty)
    );

    bc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_avoid_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (avoid_valid),
        .push_data (avoid_data),
        .pop       (a_pop),
        .pop_data  (a_data),
        .count     (avoid_count),
        .full      (a_full),
        .empty     (a_empty)
    );

    assign ctrl_ready  = !c_full;
    assign avoid_ready = !a_full;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_src     = out_src_q;

    always_comb begin
        // Round-robin only matters when both sources compete.
        sel_avoid = !a_empty;
        if (MODE == BC_MODE_RR && !a_empty && !c_empty)
            sel_avoid = (last_q == BC_SRC_CTRL);
        load  = (!out_valid_q || out_ready) && !(c_empty && a_empty) && !flush;
        c_pop = load && !sel_avoid;
        a_pop = load && sel_avoid;

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        last_d      = last_q;
        if (flush) begin
            out_valid_d = 1'b0;
            last_d      = BC_SRC_CTRL;
        end else if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_avoid ? a_data : c_data;
            out_src_d   = sel_avoid ? BC_SRC_AVOID : BC_SRC_CTRL;
            last_d      = out_src_d;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= BC_SRC_CTRL;
            last_q      <= BC_SRC_CTRL;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            last_q      <= last_d;
        end
    end

`ifdef BC_ARB_BUFFER_DROP_CNT_EN
    logic [7:0] c_drops_q, c_drops_d;
    logic [7:0] a_drops_q, a_drops_d;

    assign ctrl_drops  = c_drops_q;
    assign avoid_drops = a_drops_q;

    always_comb begin
        c_drops_d = c_drops_q;
        a_drops_d = a_drops_q;
        if (flush) begin
            c_drops_d = '0;
            a_drops_d = '0;
        end else begin
            if (ctrl_valid && c_full && c_drops_q != 8'hFF)
                c_drops_d = c_drops_q + 8'd1;
            if (avoid_valid && a_full && a_drops_q != 8'hFF)
                a_drops_d = a_drops_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_drops_q <= '0;
            a_drops_q <= '0;
        end else begin
            c_drops_q <= c_drops_d;
            a_drops_q <= a_drops_d;
        end
    end
`endif

endmodule

// File: tb/tb_bc_arb_buffer.sv
// Scoreboard bench: one priority and one round-robin buffer driven in parallel
// and checked against queue-based reference models.
module tb_bc_arb_buffer;

    localparam int DW = 16;
    localparam int DP = 8;

    logic clk, rst, fl, cv, av, ordy;
    logic [DW-1:0] cd, ad;

    logic          crw [2];
    logic          arw [2];
    logic          ovw [2];
    logic [DW-1:0] odw [2];
    logic          osw [2];
    logic [3:0]    ccw [2];
    logic [3:0]    acw [2];
`ifdef BC_ARB_BUFFER_DROP_CNT_EN
    logic [7:0]    cdw [2];
    logic [7:0]    adw [2];
`endif

    int chk = 0;
    int fails = 0;

    logic [DW-1:0] cq   [2][$];
    logic [DW-1:0] aq   [2][$];
    logic [DW:0]   expq [2][$];
    logic [DW-1:0] obs  [2][$];
    logic [DW-1:0] eseq [$];
    bit            mov  [2];
    bit            mlast[2];
    int            mcdrop[2];
    int            madrop[2];

    bc_arb_buffer #(.DATA_W(DW), .DEPTH(DP), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .flush(fl),
        .ctrl_valid(cv), .ctrl_data(cd), .ctrl_ready(crw[0]),
        .avoid_valid(av), .avoid_data(ad), .avoid_ready(arw[0]),
        .out_valid(ovw[0]), .out_data(odw[0]), .out_src(osw[0]),
        .out_ready(ordy),
`ifdef BC_ARB_BUFFER_DROP_CNT_EN
        .ctrl_drops(cdw[0]), .avoid_drops(adw[0]),
`endif
        .ctrl_count(ccw[0]), .avoid_count(acw[0])
    );

    bc_arb_buffer #(.DATA_W(DW), .DEPTH(DP), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .flush(fl),
        .ctrl_valid(cv), .ctrl_data(cd), .ctrl_ready(crw[1]),
        .avoid_valid(av), .avoid_data(ad), .avoid_ready(arw[1]),
        .out_valid(ovw[1]), .out_data(odw[1]), .out_src(osw[1]),
        .out_ready(ordy),
`ifdef BC_ARB_BUFFER_DROP_CNT_EN
        .ctrl_drops(cdw[1]), .avoid_drops(adw[1]),
`endif
        .ctrl_count(ccw[1]), .avoid_count(acw[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int i,
                         input logic [31:0] got, input logic [31:0] exp);
        chk++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s dut%0d got=%0h exp=%0h", nm, i, got, exp);
        end
    endtask

    // Reference model: queues per source, one output slot, last-served bit.
    always @(posedge clk or negedge rst) begin
        bit cr, ar, sa, ld;
        logic [DW-1:0] w;
        for (int i = 0; i < 2; i++) begin
            if (!rst || fl) begin
                cq[i].delete();
                aq[i].delete();
                expq[i].delete();
                mov[i]    = 1'b0;
                mlast[i]  = 1'b0;
                mcdrop[i] = 0;
                madrop[i] = 0;
            end else begin
                cr = (cq[i].size() < DP);
                ar = (aq[i].size() < DP);
                ld = (!mov[i] || ordy) && (cq[i].size() > 0 || aq[i].size() > 0);
                if (ld) begin
                    if (cq[i].size() > 0 && aq[i].size() > 0)
                        sa = (i == 0) ? 1'b1 : !mlast[i];
                    else
                        sa = (aq[i].size() > 0);
                    if (sa) w = aq[i].pop_front();
                    else    w = cq[i].pop_front();
                    expq[i].push_back({sa, w});
                    mov[i]   = 1'b1;
                    mlast[i] = sa;
                end else if (mov[i] && ordy) begin
                    mov[i] = 1'b0;
                end
                if (cv && cr) cq[i].push_back(cd);
                if (av && ar) aq[i].push_back(ad);
                if (cv && !cr && mcdrop[i] < 255) mcdrop[i]++;
                if (av && !ar && madrop[i] < 255) madrop[i]++;
            end
        end
    end

    // Monitor: status every cycle, scoreboard pop on each handshake.
    always @(negedge clk) begin
        logic [DW:0] e;
        for (int i = 0; i < 2; i++) begin
            check("out_valid", i, 32'(ovw[i]), 32'(mov[i]));
            check("ctrl_count", i, 32'(ccw[i]), 32'(cq[i].size()));
            check("avoid_count", i, 32'(acw[i]), 32'(aq[i].size()));
            check("ctrl_ready", i, 32'(crw[i]), 32'(cq[i].size() != DP));
            check("avoid_ready", i, 32'(arw[i]), 32'(aq[i].size() != DP));
`ifdef BC_ARB_BUFFER_DROP_CNT_EN
            check("ctrl_drops", i, 32'(cdw[i]), 32'(mcdrop[i]));
            check("avoid_drops", i, 32'(adw[i]), 32'(madrop[i]));
`endif
            if (ovw[i] && ordy) begin
                chk++;
                if (expq[i].size() == 0) begin
                    fails++;
                    $display("FAIL scoreboard dut%0d got=%0h exp=none", i, odw[i]);
                end else begin
                    chk--;
                    e = expq[i].pop_front();
                    check("out_data", i, 32'(odw[i]), 32'(e[DW-1:0]));
                    check("out_src", i, 32'(osw[i]), 32'(e[DW]));
                end
                obs[i].push_back(odw[i]);
            end
        end
    end

    task automatic step(input bit c_v, input logic [DW-1:0] c_d,
                        input bit a_v, input logic [DW-1:0] a_d,
                        input bit o_r, input bit f);
        cv = c_v; cd = c_d; av = a_v; ad = a_d; ordy = o_r; fl = f;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_obs(input int i, input string nm);
        check({nm, "_len"}, i, 32'(obs[i].size()), 32'(eseq.size()));
        for (int k = 0; k < eseq.size() && k < obs[i].size(); k++)
            check(nm, i, 32'(obs[i][k]), 32'(eseq[k]));
    endtask

    task automatic clear_obs();
        step(0, 0, 0, 0, 0, 1);
        obs[0].delete();
        obs[1].delete();
    endtask

    initial begin
        rst = 1'b0; fl = 0; cv = 0; av = 0; ordy = 0; cd = '0; ad = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_data", 0, 32'(odw[0]), 32'h0);
        rst = 1'b1;

        // Fill ctrl until full; first word sits in the output register.
        clear_obs();
        for (int v = 10; v < 20; v++) step(1, DW'(v), 0, 0, 0, 0);
        check("full_count", 0, 32'(ccw[0]), 32'd8);
        check("full_ready", 0, 32'(crw[0]), 32'd0);
        for (int k = 0; k < 12; k++) step(0, 0, 0, 0, 1, 0);
        eseq.delete();
        for (int v = 10; v < 19; v++) eseq.push_back(DW'(v));
        chk_obs(0, "fill_order");
        chk_obs(1, "fill_order");

        // Priority vs round-robin ordering.
        clear_obs();
        step(1, 16'd1, 1, 16'hA1, 0, 0);
        step(1, 16'd2, 1, 16'hA2, 0, 0);
        for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 1, 0);
        eseq = '{16'hA1, 16'hA2, 16'd1, 16'd2};
        chk_obs(0, "prio_order");
        eseq = '{16'hA1, 16'd1, 16'hA2, 16'd2};
        chk_obs(1, "rr_order");

        // Latency through an empty buffer.
        clear_obs();
        step(1, 16'h55, 0, 0, 1, 0);
        check("lat_k", 0, 32'(ovw[0]), 32'd0);
        step(0, 0, 0, 0, 1, 0);
        check("lat_k1", 0, 32'(ovw[0]), 32'd1);
        check("lat_data", 0, 32'(odw[0]), 32'h55);
        step(0, 0, 0, 0, 1, 0);
        check("lat_k2", 0, 32'(ovw[0]), 32'd0);

        // Simultaneous push and pop on one FIFO.
        clear_obs();
        for (int v = 'h20; v < 'h2A; v++) step(1, DW'(v), 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check("pp_pre", 0, 32'(ccw[0]), 32'd7);
        step(1, 16'h99, 0, 0, 1, 0);
        check("pp_post", 0, 32'(ccw[0]), 32'd7);
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 1, 0);
        eseq.delete();
        for (int v = 'h20; v < 'h29; v++) eseq.push_back(DW'(v));
        eseq.push_back(16'h99);
        chk_obs(0, "pp_order");

        // Flush while holding an output with a write pending.
        clear_obs();
        step(1, 16'h31, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("fl_pre", 0, 32'(ovw[0]), 32'd1);
        step(1, 16'h77, 0, 0, 0, 1);
        check("fl_valid", 0, 32'(ovw[0]), 32'd0);
        check("fl_count", 0, 32'(ccw[0]), 32'd0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 0);
        eseq.delete();
        chk_obs(0, "fl_absent");

`ifdef BC_ARB_BUFFER_DROP_CNT_EN
        clear_obs();
        for (int k = 0; k < 310; k++) step(1, DW'(k), 0, 0, 0, 0);
        check("drops_sat", 0, 32'(cdw[0]), 32'd255);
        clear_obs();
`endif

        // Random traffic with occasional flush and one mid-run reset.
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) begin
                rst = 1'b0;
                step(0, 0, 0, 0, 0, 0);
                step(0, 0, 0, 0, 0, 0);
                rst = 1'b1;
            end
            step(($urandom % 3) != 0, DW'($urandom),
                 ($urandom % 3) == 0, DW'($urandom),
                 ($urandom % 4) != 0, ($urandom % 64) == 0);
        end
        for (int k = 0; k < 20; k++) step(0, 0, 0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
        $finish;
    end

endmodule
